mult_unit: RTL and testbench
============================

// Module: mult_unit
// PURPOSE
//  Execute-stage responder for the multiply codes emitted by the ALU control decoder:
//  MULT (alu_ctrl=4'b0011), MFLO (4'b0101), MFHI (4'b0100).
//  Iterative radix-2 shift-add multiplier writing a private HI/LO register pair.
//  'busy' drives the pipeline stall; MFHI/MFLO reads return a registered result.
// PARAMETERS
//  WIDTH    32    operand width; HI/LO are WIDTH bits each, product is 2*WIDTH
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  op_valid      in   1      alu_ctrl/a/b valid this cycle (instruction in EX)
//  alu_ctrl      in   4      decoded ALU control code
//  a             in   WIDTH  multiplicand (rs)
//  b             in   WIDTH  multiplier (rt)
//  flush         in   1      abort in-flight MULT (branch/jump squash)
//  busy          out  1      MULT in progress; upstream holds instruction in EX
//  done          out  1      one-cycle pulse: HI/LO just updated
//  result        out  WIDTH  MFHI/MFLO read data
//  result_valid  out  1      one-cycle pulse: result holds MFHI/MFLO data
//  hi            out  WIDTH  current HI register
//  lo            out  WIDTH  current LO register
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, result_valid=0,
//   hi=0, lo=0, counter=0, internal operand/product regs=0. Aborts any in-flight MULT.
//  FSM: IDLE, BUSY.
//   IDLE: op_valid & alu_ctrl==MULT at edge E0 -> latch a,b; clear accumulator;
//    counter=WIDTH; -> BUSY. busy=1 from after E0.
//   BUSY: each edge: if multiplier LSB=1 add multiplicand to upper accumulator half;
//    shift accumulator right 1 (carry in at MSB); counter-=1.
//    At edge E_WIDTH (counter reaches 0): hi/lo <= 2*WIDTH product; -> IDLE;
//    done=1 for the following cycle only.
//  Latency: busy high exactly WIDTH cycles; hi/lo valid in the cycle done=1.
//  MFHI/MFLO: op_valid & state==IDLE -> at next edge result<=hi (MFHI) or lo (MFLO),
//   result_valid=1 for one cycle. result holds its value until the next read.
//  While BUSY all op_valid requests are ignored (no result_valid, no restart);
//   upstream stalls on busy and re-presents the op.
//  Done cycle is IDLE: an MFHI/MFLO presented while done=1 returns the new product.
//  MULT presented while done=1 starts a new multiply; hi/lo keep the old product
//   until its completion.
//  flush: in BUSY -> IDLE at next edge, busy=0, hi/lo unchanged, no done.
//   In IDLE, flush has priority: the op presented that cycle is dropped.
//  Other alu_ctrl values, including X/unknown, are ignored; no state change.
//  Arithmetic: unsigned by default; accumulator is 2*WIDTH+1 bits internally
//   (carry bit), truncated to 2*WIDTH on write.
// CONFIGURATION
//  MULT_SIGNED_EN defined: a, b are two's complement. Magnitudes are latched at E0.
//   Product is negated at the final edge if the sign bits differ. Same latency.
//   Most-negative operand uses magnitude 2^(WIDTH-1) unsigned.
//  MULT_SIGNED_EN undefined: purely unsigned (multu semantics), no sign logic.
// TESTING
//  1 reset: rst_n low at BUSY cycle 10 -> busy=0, hi=lo=0, done stays 0.
//  2 MULT a=3 b=5 -> busy 32 cycles, done pulse, hi=0 lo=15; MFLO -> result=15,
//    result_valid 1 cycle.
//  3 MULT a=b=32'hFFFFFFFF -> unsigned: hi=32'hFFFFFFFE lo=32'h00000001;
//    MULT_SIGNED_EN: hi=0 lo=1.
//  4 MFHI held during BUSY -> no result_valid until done; MFHI in done cycle
//    -> result = new hi.
//  5 MULT 7*9 then flush at BUSY cycle 10 -> busy=0 next cycle, no done,
//    hi/lo keep previous 3*5 product.
//  6 MULT_SIGNED_EN: a=-7 b=3 -> hi=32'hFFFFFFFF lo=32'hFFFFFFEB;
//    a=32'h80000000 b=2 -> hi=32'hFFFFFFFF lo=0.

Source files
------------

// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add multiplier with a private HI/LO pair.
//   MULT (4'b0011) starts a WIDTH-cycle multiply; MFHI (4'b0100) / MFLO (4'b0101)
//   return HI / LO through a registered result port.
//   Optional build macro MULT_SIGNED_EN: two's complement operands (mult);
//   without it the unit is purely unsigned (multu).
// Handshake: an op is accepted only when op_valid=1 and the unit is IDLE;
//   while busy=1 every op is ignored and upstream must hold and re-present it.
//   done / result_valid are single-cycle pulses, never back-pressured.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_MFHI = 4'b0100;
  localparam logic [3:0] OP_MFLO = 4'b0101;
  localparam int         CW      = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_final;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

`ifdef MULT_SIGNED_EN
  logic                 neg_q, neg_d;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
  end

  // Restore the sign of the product on the final step.
  always_comb begin
    prod_final = neg_q ? (~acc_step + 1'b1) : acc_step;
  end
`else
  // Unsigned: operands pass straight through.
  always_comb begin
    mag_a = a;
    mag_b = b;
  end

  // Unsigned: the accumulator already holds the product.
  always_comb begin
    prod_final = acc_step;
  end
`endif

  // One shift-add step: the WIDTH+1 bit sum keeps the carry, which becomes the
  // new MSB when the accumulator shifts right; the multiplier drains out of LSB.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  // Next-state and datapath control for the IDLE/BUSY machine.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mcand_d        = mcand_q;
    acc_d          = acc_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;
`ifdef MULT_SIGNED_EN
    neg_d          = neg_q;
`endif
    case (state_q)
      IDLE: begin
        // flush squashes whatever op is presented alongside it
        if (!flush && op_valid) begin
          case (alu_ctrl)
            OP_MULT: begin
              mcand_d = mag_a;
              acc_d   = {{WIDTH{1'b0}}, mag_b};
              cnt_d   = CW'(WIDTH);
              state_d = BUSY;
`ifdef MULT_SIGNED_EN
              neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
            end
            OP_MFHI: begin
              result_d       = hi_q;
              result_valid_d = 1'b1;
            end
            OP_MFLO: begin
              result_d       = lo_q;
              result_valid_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (flush) begin
          // abandon the multiply; HI/LO keep the previous product
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            hi_d    = prod_final[2*WIDTH-1:WIDTH];
            lo_d    = prod_final[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mcand_q        <= '0;
      acc_q          <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mcand_q        <= mcand_d;
      acc_q          <= acc_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
`ifdef MULT_SIGNED_EN
      neg_q          <= neg_d;
`endif
    end
  end

  assign busy         = (state_q == BUSY);
  assign done         = done_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed tests for mult_unit (WIDTH=32), honouring MULT_SIGNED_EN.
module tb_mult_unit;

  localparam int W = 32;
  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_MFHI = 4'b0100;
  localparam logic [3:0] OP_MFLO = 4'b0101;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         result_valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .alu_ctrl     (alu_ctrl),
    .a            (a),
    .b            (b),
    .flush        (flush),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present MULT for one edge, then drop the request
  task automatic start_mult(input logic [W-1:0] x, input logic [W-1:0] y);
    op_valid = 1'b1;
    alu_ctrl = OP_MULT;
    a        = x;
    b        = y;
    tick();
    op_valid = 1'b0;
    alu_ctrl = 4'b0000;
  endtask

  // count edges until busy falls, bounded
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic seen_done;
    rst_n = 1'b0; op_valid = 1'b0; alu_ctrl = 4'b0000;
    a = '0; b = '0; flush = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b rv=%b expected 0 0 0", busy, done, result_valid);
    end
    n_checks++;
    if (hi !== '0 || lo !== '0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_data: hi=%h lo=%h result=%h expected 0", hi, lo, result);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_mult(32'd3, 32'd5);
    repeat (9) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_busy: busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
      tick();
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: activity=%b expected 0", seen_done);
    end
  endtask

  task automatic test_mult_basic();
    int cyc;
    start_mult(32'd3, 32'd5);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b expected 1", busy);
    end
    wait_idle(cyc);
    n_checks++;
    if (cyc != W) begin
      n_fail++;
      $display("FAIL basic_latency: busy cycles=%0d expected %0d", cyc, W);
    end
    n_checks++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd15) begin
      n_fail++;
      $display("FAIL basic_product: done=%b hi=%h lo=%h expected 1 0 f", done, hi, lo);
    end
    op_valid = 1'b1; alu_ctrl = OP_MFLO;
    tick();
    op_valid = 1'b0; alu_ctrl = 4'b0000;
    n_checks++;
    if (done !== 1'b0 || result !== 32'd15 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_mflo: done=%b result=%h rv=%b expected 0 f 1", done, result, result_valid);
    end
    tick();
    n_checks++;
    if (result_valid !== 1'b0 || result !== 32'd15) begin
      n_fail++;
      $display("FAIL basic_hold: rv=%b result=%h expected 0 f", result_valid, result);
    end
  endtask

  task automatic test_flush();
    logic seen;
    start_mult(32'd7, 32'd9);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd15) begin
      n_fail++;
      $display("FAIL flush_abort: busy=%b done=%b hi=%h lo=%h expected 0 0 0 f", busy, done, hi, lo);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done !== 1'b0) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0 || lo !== 32'd15) begin
      n_fail++;
      $display("FAIL flush_no_done: done_seen=%b lo=%h expected 0 f", seen, lo);
    end
    // flush in IDLE drops the op presented in the same cycle
    flush = 1'b1; op_valid = 1'b1; alu_ctrl = OP_MULT; a = 32'd2; b = 32'd2;
    tick();
    alu_ctrl = OP_MFLO;
    tick();
    flush = 1'b0; op_valid = 1'b0; alu_ctrl = 4'b0000;
    n_checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%b rv=%b expected 0 0", busy, result_valid);
    end
  endtask

  task automatic test_ignored();
    logic bad;
    logic [3:0] codes [3];
    codes[0] = 4'b0000; codes[1] = 4'b0110; codes[2] = 4'bxxxx;
    bad = 1'b0;
    op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_ctrl = codes[i];
      tick();
      if (busy !== 1'b0 || result_valid !== 1'b0) bad = 1'b1;
    end
    op_valid = 1'b0; alu_ctrl = 4'b0000;
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_codes: reacted=%b expected 0", bad);
    end
  endtask

  task automatic test_max();
    int cyc;
    start_mult(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(cyc);
`ifdef MULT_SIGNED_EN
    n_checks++;
    if (cyc != W || done !== 1'b1 || hi !== 32'h0 || lo !== 32'h1) begin
      n_fail++;
      $display("FAIL max_signed: cyc=%0d done=%b hi=%h lo=%h expected 32 1 0 1", cyc, done, hi, lo);
    end
`else
    n_checks++;
    if (cyc != W || done !== 1'b1 || hi !== 32'hFFFFFFFE || lo !== 32'h1) begin
      n_fail++;
      $display("FAIL max_unsigned: cyc=%0d done=%b hi=%h lo=%h expected 32 1 fffffffe 1", cyc, done, hi, lo);
    end
`endif
  endtask

  // MULT issued in the done cycle of the previous one
  task automatic test_back_to_back();
    int cyc;
    logic [W-1:0] old_hi;
`ifdef MULT_SIGNED_EN
    old_hi = 32'h0;
`else
    old_hi = 32'hFFFFFFFE;
`endif
    start_mult(32'd2, 32'd4);
    n_checks++;
    if (busy !== 1'b1 || hi !== old_hi || lo !== 32'h1) begin
      n_fail++;
      $display("FAIL b2b_start: busy=%b hi=%h lo=%h expected 1 %h 1", busy, hi, lo, old_hi);
    end
    wait_idle(cyc);
    n_checks++;
    if (cyc != W || done !== 1'b1 || hi !== 32'h0 || lo !== 32'd8) begin
      n_fail++;
      $display("FAIL b2b_product: cyc=%0d done=%b hi=%h lo=%h expected 32 1 0 8", cyc, done, hi, lo);
    end
  endtask

  task automatic test_mfhi_during_busy();
    int cyc;
    logic seen;
    start_mult(32'h00010000, 32'h00030000);
    op_valid = 1'b1; alu_ctrl = OP_MFHI;
    cyc = 0; seen = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      if (result_valid !== 1'b0) seen = 1'b1;
      tick();
      cyc++;
    end
    n_checks++;
    if (seen !== 1'b0 || result_valid !== 1'b0 || cyc != W) begin
      n_fail++;
      $display("FAIL mfhi_busy: rv_seen=%b rv=%b cyc=%0d expected 0 0 32", seen, result_valid, cyc);
    end
    n_checks++;
    if (done !== 1'b1 || hi !== 32'd3 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL mfhi_product: done=%b hi=%h lo=%h expected 1 3 0", done, hi, lo);
    end
    tick();
    op_valid = 1'b0; alu_ctrl = 4'b0000;
    n_checks++;
    if (result_valid !== 1'b1 || result !== 32'd3) begin
      n_fail++;
      $display("FAIL mfhi_done_read: rv=%b result=%h expected 1 3", result_valid, result);
    end
  endtask

  task automatic test_sign_cases();
    int cyc;
`ifdef MULT_SIGNED_EN
    start_mult(32'hFFFFFFF9, 32'd3);
    wait_idle(cyc);
    n_checks++;
    if (cyc != W || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      n_fail++;
      $display("FAIL signed_neg7x3: cyc=%0d hi=%h lo=%h expected 32 ffffffff ffffffeb", cyc, hi, lo);
    end
    tick();
    start_mult(32'h80000000, 32'd2);
    wait_idle(cyc);
    n_checks++;
    if (cyc != W || hi !== 32'hFFFFFFFF || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL signed_minx2: cyc=%0d hi=%h lo=%h expected 32 ffffffff 0", cyc, hi, lo);
    end
`else
    start_mult(32'h80000000, 32'd2);
    wait_idle(cyc);
    n_checks++;
    if (cyc != W || hi !== 32'h1 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL unsigned_msbx2: cyc=%0d hi=%h lo=%h expected 32 1 0", cyc, hi, lo);
    end
    tick();
    start_mult(32'h12345678, 32'h9ABCDEF0);
    wait_idle(cyc);
    n_checks++;
    if (cyc != W || hi !== 32'h0B00EA4E || lo !== 32'h242D2080) begin
      n_fail++;
      $display("FAIL unsigned_mixed: cyc=%0d hi=%h lo=%h expected 32 0b00ea4e 242d2080", cyc, hi, lo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    tick();
    test_flush();
    test_ignored();
    test_max();
    test_back_to_back();
    tick();
    test_mfhi_during_busy();
    tick();
    test_sign_cases();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
